// File: rtl/bp_be_fe_queue_ckpt.sv
// FE->BE instruction queue with speculative reads, multi-entry commit, replay (roll) and
// discard of unread entries (clr). Three wrap-bit pointers: commit <= read <= write.
module bp_be_fe_queue_ckpt #(
  parameter int unsigned width_p     = 128,
  parameter int unsigned els_p       = 8,
  parameter int unsigned deq_width_p = 2,
  localparam int unsigned cnt_width_lp     = $clog2(els_p + 1),
  localparam int unsigned deq_cnt_width_lp = $clog2(deq_width_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [width_p-1:0]          data_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic [width_p-1:0]          data_o,
  output logic                        v_o,
  input  logic                        yumi_i,
  input  logic [deq_cnt_width_lp-1:0] deq_cnt_i,
  input  logic                        roll_i,
  input  logic                        clr_i,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [cnt_width_lp-1:0]     unread_cnt_o,
  output logic [cnt_width_lp-1:0]     spec_cnt_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp = idx_width_lp + 1;

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [ptr_width_lp-1:0] occupancy;
  logic [ptr_width_lp-1:0] unread;
  logic [ptr_width_lp-1:0] spec;
  logic                    enq;

  // Slots are freed only on commit, so occupancy spans commit to write pointer.
  assign occupancy    = wptr_q - cptr_q;
  assign unread       = wptr_q - rptr_q;
  assign spec         = rptr_q - cptr_q;
  assign full_o       = (occupancy == ptr_width_lp'(els_p));
  assign ready_o      = ~full_o;
  assign empty_o      = (wptr_q == cptr_q);
  assign v_o          = (rptr_q != wptr_q);
  assign unread_cnt_o = cnt_width_lp'(unread);
  assign spec_cnt_o   = cnt_width_lp'(spec);
  assign data_o       = mem_q[rptr_q[idx_width_lp-1:0]];
  assign enq          = v_i & ready_o;

  // Commit, then read, then write: each later pointer may snap to the earlier one's next value.
  always_comb begin
    cptr_d = cptr_q + ptr_width_lp'(deq_cnt_i);
    rptr_d = roll_i ? cptr_d : (rptr_q + ptr_width_lp'(yumi_i));
    wptr_d = clr_i ? rptr_d : (wptr_q + ptr_width_lp'(enq));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq & ~clr_i & ~reset_i) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o && !roll_i))
        else $error("yumi_i asserted with no unread entry");
      assert (cnt_width_lp'(deq_cnt_i) <= spec_cnt_o)
        else $error("deq_cnt_i exceeds speculative entry count");
      assert (deq_cnt_i <= deq_cnt_width_lp'(deq_width_p))
        else $error("deq_cnt_i exceeds deq_width_p");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Scoreboard bench for bp_be_fe_queue_ckpt: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares consumed data and status snapshots.
module tb_bp_be_fe_queue_ckpt;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        v_o;
  logic        yumi_i;
  logic [1:0]  deq_cnt_i;
  logic        roll_i;
  logic        clr_i;
  logic        empty_o;
  logic        full_o;
  logic [3:0]  unread_cnt_o;
  logic [3:0]  spec_cnt_o;

  bp_be_fe_queue_ckpt #(
    .width_p    (16),
    .els_p      (8),
    .deq_width_p(2)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .v_o         (v_o),
    .yumi_i      (yumi_i),
    .deq_cnt_i   (deq_cnt_i),
    .roll_i      (roll_i),
    .clr_i       (clr_i),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .unread_cnt_o(unread_cnt_o),
    .spec_cnt_o  (spec_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         tag;
    logic       v;
    logic       ready;
    logic       empty;
    logic       full;
    logic [3:0] unread;
    logic [3:0] spec;
    logic       dchk;
    logic [15:0] data;
  } stat_t;

  logic [15:0] data_q [$];
  stat_t       stat_q [$];
  logic        chk_req;
  int          checks;
  int          errors;
  int          stat_tag;
  int          rd_tag;

  task automatic cmp(input string what, input int tag, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", what, tag, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    stat_t       s;
    logic [15:0] e;
    if (!reset_i) begin
      if (yumi_i && !roll_i) begin
        if (data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read #%0d: yumi with no expected entry", rd_tag);
        end else begin
          e = data_q.pop_front();
          cmp("v_o_at_read", rd_tag, 16'(v_o), 16'd1);
          cmp("read_data", rd_tag, data_o, e);
        end
        rd_tag++;
      end
      if (chk_req && stat_q.size() != 0) begin
        s = stat_q.pop_front();
        cmp("v_o", s.tag, 16'(v_o), 16'(s.v));
        cmp("ready_o", s.tag, 16'(ready_o), 16'(s.ready));
        cmp("empty_o", s.tag, 16'(empty_o), 16'(s.empty));
        cmp("full_o", s.tag, 16'(full_o), 16'(s.full));
        cmp("unread_cnt_o", s.tag, 16'(unread_cnt_o), 16'(s.unread));
        cmp("spec_cnt_o", s.tag, 16'(spec_cnt_o), 16'(s.spec));
        if (s.dchk) cmp("data_o", s.tag, data_o, s.data);
      end
    end
  end

  // Inputs for one cycle, applied just after the edge and cleared after the next one.
  task automatic cyc(input logic v, input logic [15:0] d, input logic y, input logic [15:0] e,
                     input logic [1:0] dq, input logic roll, input logic clr);
    v_i = v; data_i = d; yumi_i = y; deq_cnt_i = dq; roll_i = roll; clr_i = clr;
    if (y && !roll) data_q.push_back(e);
    @(posedge clk_i);
    #1;
    v_i = 1'b0; yumi_i = 1'b0; deq_cnt_i = 2'd0; roll_i = 1'b0; clr_i = 1'b0; chk_req = 1'b0;
  endtask

  task automatic enq(input logic [15:0] d);
    cyc(1'b1, d, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] e, input logic [1:0] dq);
    cyc(1'b0, 16'h0, 1'b1, e, dq, 1'b0, 1'b0);
  endtask

  task automatic commit(input logic [1:0] dq);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, dq, 1'b0, 1'b0);
  endtask

  // Expectation about the outputs during the next cycle issued.
  task automatic expect_st(input logic v, input logic ready, input logic empty, input logic full,
                           input logic [3:0] unread, input logic [3:0] spec, input logic dchk,
                           input logic [15:0] d);
    stat_q.push_back('{stat_tag, v, ready, empty, full, unread, spec, dchk, d});
    stat_tag++;
    chk_req = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; stat_tag = 0; rd_tag = 0; chk_req = 1'b0;
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; yumi_i = 1'b0; deq_cnt_i = '0;
    roll_i = 1'b0; clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Reset state, then A,B,C with no reads; v_o rises the cycle after A is written.
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    enq(16'h00A0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 16'h00A0);
    enq(16'h00B0);
    enq(16'h00C0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 16'h00A0);
    commit(2'd0);

    // Read A,B then commit both; C stays unread.
    rd(16'h00A0, 2'd0);
    rd(16'h00B0, 2'd0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 16'h00C0);
    commit(2'd2);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 16'h00C0);
    rd(16'h00C0, 2'd0);
    commit(2'd1);
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    commit(2'd0);

    // Fill to capacity; a 9th enqueue is refused.
    for (int i = 0; i < 8; i++) enq(16'h1000 + 16'(i));
    expect_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 16'h1000);
    enq(16'hDEAD);
    expect_st(1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 16'h1000);
    commit(2'd0);
    for (int i = 0; i < 8; i++) rd(16'h1000 + 16'(i), 2'd0);
    // Speculative entries still hold their slots; same-cycle enqueue+commit is refused.
    expect_st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd8, 1'b0, 16'h0);
    cyc(1'b1, 16'hBEEF, 1'b0, 16'h0, 2'd2, 1'b0, 1'b0);
    expect_st(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, 16'h0);
    commit(2'd2);
    commit(2'd2);
    commit(2'd2);
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    commit(2'd0);

    // Three full wraps, committing each entry the cycle after it is read.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) enq(16'h2000 + 16'(r * 16 + i));
      for (int i = 0; i < 8; i++) rd(16'h2000 + 16'(r * 16 + i), (i == 0) ? 2'd0 : 2'd1);
      commit(2'd1);
      expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
      commit(2'd0);
    end

    // Roll: read A,B,C, commit A, replay from B.
    enq(16'h000A); enq(16'h000B); enq(16'h000C); enq(16'h000D);
    rd(16'h000A, 2'd0); rd(16'h000B, 2'd0); rd(16'h000C, 2'd0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 16'h000D);
    commit(2'd1);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 16'h000D);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 16'h000B);
    rd(16'h000B, 2'd0);
    cyc(1'b1, 16'h000E, 1'b1, 16'h000C, 2'd0, 1'b0, 1'b0);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 1'b1, 16'h000D);
    commit(2'd0);

    // clr with enqueue and read in the same cycle: D consumed, E discarded, F dropped.
    cyc(1'b1, 16'h000F, 1'b1, 16'h000D, 2'd0, 1'b0, 1'b1);
    expect_st(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 16'h0);
    commit(2'd0);

    // roll & clr together with a commit empties the queue.
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 2'd1, 1'b1, 1'b1);
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    enq(16'h00A7);
    enq(16'h00A8);
    rd(16'h00A7, 2'd0);

    // Reset mid-stream has priority over a concurrent enqueue.
    reset_i = 1'b1; v_i = 1'b1; data_i = 16'hDEAD;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0; v_i = 1'b0;
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    enq(16'h0050);
    expect_st(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 16'h0050);
    rd(16'h0050, 2'd0);
    commit(2'd1);
    expect_st(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    commit(2'd0);
    repeat (2) @(posedge clk_i);

    checks++;
    if (data_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d reads %0d snapshots pending, expected 0 0",
               data_q.size(), stat_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_ckpt.md
Name: bp_be_fe_queue_ckpt

Overview:
- Rollback-capable FE→BE instruction queue between the frontend queue interface and the backend scheduler.
- Generalises the clr/deq/roll queue control: parametrised entry width and depth, plus multi-entry commit per cycle.
- Entries move through three states: unread, read-but-uncommitted (speculative), and free.
- The backend can replay speculatively read entries (roll) or discard unread entries (clr).

Parameters:
- width_p, 128, entry width in bits (fe_queue_width_lp at instantiation).
- els_p, 8, entry count; power of 2, ≥2.
- deq_width_p, 2, maximum entries committed per cycle; 1 ≤ deq_width_p ≤ els_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- data_i  in  width_p  enqueue entry.
- v_i  in  1  enqueue valid.
- ready_o  out  1  space available; the enqueue fires on v_i & ready_o.
- data_o  out  width_p  entry at the speculative read pointer.
- v_o  out  1  data_o holds an unread entry.
- yumi_i  in  1  consume data_o; legal only when v_o.
- deq_cnt_i  in  $clog2(deq_width_p+1)  number of oldest speculative entries to commit this cycle.
- roll_i  in  1  replay: rewind the read pointer to the commit pointer.
- clr_i  in  1  drop every unread entry.
- empty_o  out  1  no entries held (committed pointer == write pointer).
- full_o  out  1  els_p entries held.
- unread_cnt_o  out  $clog2(els_p+1)  wptr − rptr.
- spec_cnt_o  out  $clog2(els_p+1)  rptr − cptr.

Behaviour:
- State is three pointers (wptr, rptr, cptr), each $clog2(els_p)+1 bits wide; the extra MSB is a wrap bit.
- Storage index is the low bits. Invariant: cptr ≤ rptr ≤ wptr, modulo wrap.
- Occupancy is wptr − cptr. full_o = (occupancy == els_p); ready_o = ~full_o.
- Slots stay allocated until committed, so speculative entries block new enqueues.
- v_o = (rptr != wptr).
- data_o = mem[rptr] combinationally, zero latency. Its value is don't-care when v_o = 0.
- Enqueue writes mem[wptr] at the clock edge. There is no write→read bypass: the entry appears on data_o the next cycle at the earliest.
- Next-state rules, evaluated in this order within one cycle:
  1. cptr_n = cptr + deq_cnt_i.
  2. rptr_n = roll_i ? cptr_n : rptr + yumi_i. yumi_i is ignored while roll_i is high.
  3. wptr_n = clr_i ? rptr_n : wptr + (v_i & ready_o). While clr_i is high the enqueue is dropped and is not written.
- roll_i & clr_i together empty the queue: all three pointers become cptr_n.
- deq_cnt_i may commit entries read in an earlier cycle only. Legal range: deq_cnt_i ≤ spec_cnt_o (start-of-cycle value).
- A same-cycle yumi entry cannot be committed that cycle.
- Enqueue and commit in the same cycle while full: ready_o stays 0 (registered occupancy), so the enqueue is refused. A slot freed by a commit is available the following cycle.
- Wrap-around: pointers increment modulo 2·els_p. Full/empty are distinguished by the wrap bit.
- Reset (synchronous, reset_i high at the edge): all pointers → 0.
  - Resulting outputs: v_o = 0, ready_o = 1, empty_o = 1, full_o = 0, both counts = 0.
  - Storage is not reset.
  - Reset mid-operation discards all entries, with priority over every other input that cycle.
- Assertions (simulation only, ignored during reset):
  - yumi_i & ~v_o & ~roll_i
  - deq_cnt_i > spec_cnt_o
  - deq_cnt_i > deq_width_p
- Target 150–250 lines of RTL: 1R1W storage array, three pointer registers, count logic, assertions.

Test Plan:
- Reset, then enqueue A,B,C on consecutive cycles with yumi_i held 0 → v_o rises the cycle after A is written; data_o = A; unread_cnt_o = 3; spec_cnt_o = 0.
- From that state, yumi two cycles (A, B), then deq_cnt_i = 2 → spec_cnt_o = 2 then 0; data_o = C; occupancy = 1.
- els_p = 8: enqueue 8 entries without commit → full_o = 1, ready_o = 0, and a 9th v_i is not accepted. Read all 8, commit 2 → ready_o = 1 the next cycle. Continue for 3 full wraps and check FIFO order.
- Read A, B, C (spec_cnt_o = 3), commit 1, then roll_i → next cycle data_o = B, spec_cnt_o = 0, unread_cnt_o = 2 plus any remaining unread entries.
- 4 entries held with 2 read; pulse clr_i together with v_i and yumi_i → wptr = rptr_n; unread_cnt_o = 0; v_o = 0; the new entry is dropped; spec_cnt_o = 3.
- Pulse roll_i & clr_i with deq_cnt_i = 1 → empty_o = 1 next cycle. Separately, assert reset_i mid-stream with v_i = 1 → all counts 0, v_o = 0, ready_o = 1; first post-reset enqueue appears on data_o one cycle later.
